// File: rtl/memory_sub_system_param.sv
// Shared parameters and state type for the direct-mapped cache subsystem.
package memory_sub_system_param;

    localparam int unsigned ADDR_WIDTH      = 32;
    localparam int unsigned OFFSET_LENGTH   = 4;
    localparam int unsigned INDEX_LENGTH    = 8;
    localparam int unsigned TAG_LENGTH      = ADDR_WIDTH - INDEX_LENGTH - OFFSET_LENGTH;
    localparam int unsigned NUM_CACHE_LINES = 2 ** INDEX_LENGTH;

    typedef enum logic [1:0] {
        StIdle,
        StCompare,
        StWriteback,
        StAllocate
    } cache_state_t;

    // Build a line-aligned byte address from a tag and an index.
    function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [TAG_LENGTH-1:0]   tag,
                                                        input logic [INDEX_LENGTH-1:0] index);
        return {tag, index, {OFFSET_LENGTH{1'b0}}};
    endfunction

endpackage

// File: rtl/tag_mem.sv
// Tag storage for the direct-mapped cache: combinational read, registered write.
// Contents are deliberately not cleared; the controller's valid bits mask stale tags.
module tag_mem
    import memory_sub_system_param::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [INDEX_LENGTH-1:0] index_i,
    input  logic                    write_i,
    input  logic [TAG_LENGTH-1:0]   tag_i,
    output logic [TAG_LENGTH-1:0]   tag_o
);

    logic [TAG_LENGTH-1:0] mem_q [NUM_CACHE_LINES];

    // Registered tag write; suppressed while reset is held so an abandoned refill leaves no trace.
    always_ff @(posedge clk_i) begin
        if (write_i && rst_ni) begin
            mem_q[index_i] <= tag_i;
        end
    end

    assign tag_o = mem_q[index_i];

endmodule

// File: rtl/dm_cache_controller.sv
// Sequencing controller for the direct-mapped cache: lookup, dirty writeback,
// refill over a valid/ready handshake, data-array strobes and saturating counters.
module dm_cache_controller
    import memory_sub_system_param::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_req_valid,
    input  logic                    cpu_req_write,
    input  logic [ADDR_WIDTH-1:0]   cpu_req_addr,
    output logic                    cpu_ready,
    output logic                    cpu_resp_valid,
    output logic                    mem_req_valid,
    output logic                    mem_req_write,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic                    mem_ready,
    output logic                    data_write,
    output logic                    data_fill_sel,
    output logic [INDEX_LENGTH-1:0] data_index,
    output logic [CNT_WIDTH-1:0]    hit_count,
    output logic [CNT_WIDTH-1:0]    miss_count
);

    localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

    cache_state_t                state_q, state_d;
    logic [TAG_LENGTH-1:0]       req_tag_q, req_tag_d;
    logic [INDEX_LENGTH-1:0]     req_index_q, req_index_d;
    logic                        req_write_q, req_write_d;
    logic [NUM_CACHE_LINES-1:0]  valid_q, valid_d;
    logic [NUM_CACHE_LINES-1:0]  dirty_q, dirty_d;
    logic                        refill_q, refill_d;
    logic [CNT_WIDTH-1:0]        hit_count_q, hit_count_d;
    logic [CNT_WIDTH-1:0]        miss_count_q, miss_count_d;

    logic                        tag_write;
    logic                        data_write_raw;
    logic [TAG_LENGTH-1:0]       tag_out;
    logic                        hit;

    tag_mem u_tag_mem (
        .clk_i   (clk),
        .rst_ni  (~reset),
        .index_i (req_index_q),
        .write_i (tag_write),
        .tag_i   (req_tag_q),
        .tag_o   (tag_out)
    );

    assign hit        = valid_q[req_index_q] && (tag_out == req_tag_q);
    assign data_index = req_index_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    // A reset landing on a refill cycle must not disturb the data array.
    assign data_write = data_write_raw & ~reset;

    // State and bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            req_tag_q    <= '0;
            req_index_q  <= '0;
            req_write_q  <= 1'b0;
            valid_q      <= '0;
            dirty_q      <= '0;
            refill_q     <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            req_tag_q    <= req_tag_d;
            req_index_q  <= req_index_d;
            req_write_q  <= req_write_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            refill_q     <= refill_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Next-state logic and all handshake/strobe outputs.
    always_comb begin
        state_d        = state_q;
        req_tag_d      = req_tag_q;
        req_index_d    = req_index_q;
        req_write_d    = req_write_q;
        valid_d        = valid_q;
        dirty_d        = dirty_q;
        refill_d       = refill_q;
        hit_count_d    = hit_count_q;
        miss_count_d   = miss_count_q;
        cpu_ready      = 1'b0;
        cpu_resp_valid = 1'b0;
        mem_req_valid  = 1'b0;
        mem_req_write  = 1'b0;
        mem_req_addr   = '0;
        data_write_raw = 1'b0;
        data_fill_sel  = 1'b0;
        tag_write      = 1'b0;

        unique case (state_q)
            StIdle: begin
                cpu_ready = 1'b1;
                if (cpu_req_valid) begin
                    req_tag_d   = cpu_req_addr[ADDR_WIDTH-1 -: TAG_LENGTH];
                    req_index_d = cpu_req_addr[OFFSET_LENGTH +: INDEX_LENGTH];
                    req_write_d = cpu_req_write;
                    state_d     = StCompare;
                end
            end
            StCompare: begin
                refill_d = 1'b0;
                if (hit) begin
                    cpu_resp_valid = 1'b1;
                    if (req_write_q) begin
                        data_write_raw       = 1'b1;
                        dirty_d[req_index_q] = 1'b1;
                    end
                    // The re-compare after a refill was already counted as a miss.
                    if (!refill_q && hit_count_q != CntMax) begin
                        hit_count_d = hit_count_q + CNT_WIDTH'(1);
                    end
                    state_d = StIdle;
                end else begin
                    if (miss_count_q != CntMax) begin
                        miss_count_d = miss_count_q + CNT_WIDTH'(1);
                    end
                    if (valid_q[req_index_q] && dirty_q[req_index_q]) begin
                        state_d = StWriteback;
                    end else begin
                        state_d = StAllocate;
                    end
                end
            end
            StWriteback: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = line_addr(tag_out, req_index_q);
                if (mem_ready) begin
                    state_d = StAllocate;
                end
            end
            StAllocate: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = line_addr(req_tag_q, req_index_q);
                if (mem_ready) begin
                    data_write_raw       = 1'b1;
                    data_fill_sel        = 1'b1;
                    tag_write            = 1'b1;
                    valid_d[req_index_q] = 1'b1;
                    dirty_d[req_index_q] = 1'b0;
                    refill_d             = 1'b1;
                    state_d              = StCompare;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_dm_cache_controller.sv
// Directed bench for dm_cache_controller: a line-level cache model drives per-cycle
// expectations that one negedge process compares against the DUT.
module tb_dm_cache_controller;
    import memory_sub_system_param::*;

    localparam int unsigned CW     = 4;
    localparam int          CNTMAX = (1 << CW) - 1;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    cpu_req_valid = 1'b0;
    logic                    cpu_req_write = 1'b0;
    logic [ADDR_WIDTH-1:0]   cpu_req_addr = '0;
    logic                    cpu_ready;
    logic                    cpu_resp_valid;
    logic                    mem_req_valid;
    logic                    mem_req_write;
    logic [ADDR_WIDTH-1:0]   mem_req_addr;
    logic                    mem_ready = 1'b0;
    logic                    data_write;
    logic                    data_fill_sel;
    logic [INDEX_LENGTH-1:0] data_index;
    logic [CW-1:0]           hit_count;
    logic [CW-1:0]           miss_count;

    always #5 clk = ~clk;

    dm_cache_controller #(.CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_write  (cpu_req_write),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_ready      (cpu_ready),
        .cpu_resp_valid (cpu_resp_valid),
        .mem_req_valid  (mem_req_valid),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_ready      (mem_ready),
        .data_write     (data_write),
        .data_fill_sel  (data_fill_sel),
        .data_index     (data_index),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cache model: per-line valid/dirty/tag, plus saturating counters.
    bit          mv [NUM_CACHE_LINES];
    bit          md [NUM_CACHE_LINES];
    logic [19:0] mt [NUM_CACHE_LINES];
    int          m_hit, m_miss;
    logic [7:0]  cur_idx;

    // Expected outputs for the current cycle.
    bit          chk_en = 1'b0;
    logic        e_ready, e_resp, e_mvalid, e_mwrite, e_dwrite, e_sel;
    logic [31:0] e_maddr;
    logic [31:0] seen_wb_addr, seen_alloc_addr;

    task automatic model_reset();
        for (int i = 0; i < NUM_CACHE_LINES; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
        m_hit   = 0;
        m_miss  = 0;
        cur_idx = '0;
    endtask

    task automatic set_quiet();
        e_ready  = 1'b0;
        e_resp   = 1'b0;
        e_mvalid = 1'b0;
        e_mwrite = 1'b0;
        e_dwrite = 1'b0;
        e_sel    = 1'b0;
        e_maddr  = '0;
    endtask

    task automatic set_idle();
        set_quiet();
        e_ready = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison against the model's expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cpu_ready", {31'b0, cpu_ready}, {31'b0, e_ready});
            check("cpu_resp_valid", {31'b0, cpu_resp_valid}, {31'b0, e_resp});
            check("mem_req_valid", {31'b0, mem_req_valid}, {31'b0, e_mvalid});
            check("data_write", {31'b0, data_write}, {31'b0, e_dwrite});
            check("data_index", {24'b0, data_index}, {24'b0, cur_idx});
            check("hit_count", {28'b0, hit_count}, m_hit);
            check("miss_count", {28'b0, miss_count}, m_miss);
            if (e_mvalid) begin
                check("mem_req_write", {31'b0, mem_req_write}, {31'b0, e_mwrite});
                check("mem_req_addr", mem_req_addr, e_maddr);
            end
            if (e_dwrite) check("data_fill_sel", {31'b0, data_fill_sel}, {31'b0, e_sel});
            if (mem_req_valid && mem_req_write) seen_wb_addr = mem_req_addr;
            if (mem_req_valid && !mem_req_write) seen_alloc_addr = mem_req_addr;
        end
    end

    // One CPU request; abort_at >= 0 asserts reset in that refill-wait cycle instead.
    task automatic do_req(input bit wr, input logic [31:0] addr, input int wb_dly,
                          input int fill_dly, input int abort_at);
        logic [7:0]  idx;
        logic [19:0] tag;
        idx = addr[11:4];
        tag = addr[31:12];
        set_idle();
        cpu_req_valid = 1'b1;
        cpu_req_write = wr;
        cpu_req_addr  = addr;
        step();
        // Scramble the request inputs; the controller must have latched them.
        cpu_req_valid = 1'b0;
        cpu_req_write = ~wr;
        cpu_req_addr  = ~addr;
        cur_idx = idx;
        set_quiet();
        if (mv[idx] && mt[idx] == tag) begin
            e_resp   = 1'b1;
            e_dwrite = wr;
            step();
            if (wr) md[idx] = 1'b1;
            if (m_hit < CNTMAX) m_hit++;
        end else begin
            step();
            if (m_miss < CNTMAX) m_miss++;
            if (mv[idx] && md[idx]) begin
                for (int k = 0; k <= wb_dly; k++) begin
                    set_quiet();
                    e_mvalid  = 1'b1;
                    e_mwrite  = 1'b1;
                    e_maddr   = {mt[idx], idx, 4'h0};
                    mem_ready = (k == wb_dly);
                    step();
                    mem_ready = 1'b0;
                end
            end
            for (int k = 0; k <= fill_dly; k++) begin
                set_quiet();
                e_mvalid = 1'b1;
                e_maddr  = {tag, idx, 4'h0};
                if (k == abort_at) begin
                    reset = 1'b1;
                    step();
                    reset = 1'b0;
                    model_reset();
                    set_idle();
                    return;
                end
                mem_ready = (k == fill_dly);
                e_dwrite  = (k == fill_dly);
                e_sel     = 1'b1;
                step();
                mem_ready = 1'b0;
            end
            mv[idx] = 1'b1;
            md[idx] = 1'b0;
            mt[idx] = tag;
            set_quiet();
            e_resp   = 1'b1;
            e_dwrite = wr;
            step();
            if (wr) md[idx] = 1'b1;
        end
        set_idle();
    endtask

    initial begin
        model_reset();
        set_idle();
        step();
        step();
        reset  = 1'b0;
        chk_en = 1'b1;
        check("reset_mem_req_addr", mem_req_addr, 32'h0);

        // Clean miss, refill after 2 wait cycles.
        do_req(1'b0, 32'h0000_1040, 0, 2, -1);
        check("first_refill_addr", seen_alloc_addr, 32'h0000_1040);
        check("first_miss_count", {28'b0, miss_count}, 32'd1);
        check("first_hit_count", {28'b0, hit_count}, 32'd0);

        // Hit on the same line.
        do_req(1'b0, 32'h0000_1048, 0, 0, -1);
        check("second_hit_count", {28'b0, hit_count}, 32'd1);

        // Store hit dirties the line, then a conflicting load forces a writeback.
        do_req(1'b1, 32'h0000_1044, 0, 0, -1);
        do_req(1'b0, 32'h0000_2040, 1, 0, -1);
        check("wb_addr", seen_wb_addr, 32'h0000_1040);
        check("alloc_after_wb_addr", seen_alloc_addr, 32'h0000_2040);
        check("miss_after_wb", {28'b0, miss_count}, 32'd2);

        // Long refill wait on a different line.
        do_req(1'b0, 32'h0000_3080, 0, 10, -1);

        // Stray mem_ready while idle must be ignored.
        set_idle();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();

        // Store miss on a clean line, then its writeback on conflict.
        do_req(1'b1, 32'h0000_5044, 0, 1, -1);
        do_req(1'b0, 32'h0000_4040, 2, 0, -1);
        check("store_miss_wb_addr", seen_wb_addr, 32'h0000_5040);

        // Reset during refill wait, then the same load misses again.
        do_req(1'b0, 32'h0000_6040, 0, 5, 3);
        step();
        do_req(1'b0, 32'h0000_6040, 0, 0, -1);
        check("miss_after_abort", {28'b0, miss_count}, 32'd1);

        // Hit counter saturation.
        for (int i = 0; i < 16; i++) do_req(1'b0, 32'h0000_6040 + 32'(i % 16), 0, 0, -1);
        check("hit_saturated", {28'b0, hit_count}, 32'd15);

        step();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dm_cache_controller.md
# dm_cache_controller

Sequencing controller for the direct-mapped cache. Accepts one CPU load/store request at a time and looks it up in an internal `tag_mem` instance plus controller-owned valid/dirty bits. On a hit it completes in one compare cycle; on a miss it writes back a dirty victim line and refills from main memory over a valid/ready handshake. It also drives the data-array write strobes and keeps saturating hit/miss counters.

## Interface
Parameters:
- `ADDR_WIDTH`, package, default 32: byte address width.
- `OFFSET_LENGTH`, package, default 4: line-offset bits.
- `INDEX_LENGTH`, package, default 8: index bits; `NUM_CACHE_LINES` = 2**INDEX_LENGTH.
- `TAG_LENGTH`, package, default ADDR_WIDTH-INDEX_LENGTH-OFFSET_LENGTH: tag bits.
- `CNT_WIDTH`, default 16: counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_req_valid`  in  1  CPU request present.
- `cpu_req_write`  in  1  1 = store, 0 = load.
- `cpu_req_addr`  in  ADDR_WIDTH  byte address.
- `cpu_ready`  out  1  controller can accept a request.
- `cpu_resp_valid`  out  1  one-cycle pulse; request complete.
- `mem_req_valid`  out  1  main-memory request.
- `mem_req_write`  out  1  1 = writeback, 0 = refill.
- `mem_req_addr`  out  ADDR_WIDTH  line-aligned address (offset bits zero).
- `mem_ready`  in  1  one-cycle pulse; transfer done.
- `data_write`  out  1  data-array write strobe.
- `data_fill_sel`  out  1  1 = memory fill data, 0 = CPU store data.
- `data_index`  out  INDEX_LENGTH  data-array line select.
- `hit_count`, `miss_count`  out  CNT_WIDTH  saturating counters.

## Operation
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE: `cpu_ready`=1. When `cpu_req_valid` is high, latch addr/write into `req_*` and go to COMPARE. There is no other accept path.
- Address fields: tag = addr[ADDR_WIDTH-1 -: TAG_LENGTH]; index = addr[OFFSET_LENGTH +: INDEX_LENGTH].
- `tag_mem` index and `data_index` are always driven by `req_index`.
- `tag_mem` read is combinational and its write is registered.
- COMPARE: hit = valid[idx] && tag_out == req_tag.
  - Hit: pulse `cpu_resp_valid`. If a store, pulse `data_write` (sel 0) and set dirty[idx]. Go to IDLE.
  - Miss with valid and dirty: go to WRITEBACK.
  - Miss otherwise: go to ALLOCATE.
- WRITEBACK: `mem_req_valid`=1, `mem_req_write`=1, addr={tag_out, idx, 0}. Hold until `mem_ready`, then go to ALLOCATE.
- ALLOCATE: `mem_req_valid`=1, `mem_req_write`=0, addr={req_tag, idx, 0}. On `mem_ready`, in the same cycle:
  - pulse `data_write` (sel 1) and `tag_mem.write` with tag_in = req_tag;
  - set valid[idx] and clear dirty[idx];
  - set `refill` flag and go to COMPARE. The re-compare hits and completes the request.
- Counters:
  - `miss_count` increments on a COMPARE miss.
  - `hit_count` increments on a COMPARE hit only when `refill`=0. `refill` clears on leaving COMPARE.
  - Both saturate at all-ones and never wrap.
- Valid/dirty are registers of NUM_CACHE_LINES bits. `tag_mem` contents are not reset; valid=0 masks them.

## Timing
- Reset values:
  - state IDLE, `cpu_ready`=1;
  - all strobes and valid outputs 0, `mem_req_addr`=0, `data_index`=0;
  - counters 0, valid/dirty all 0, `refill`=0.
- Hit: accept at cycle T, `cpu_resp_valid` at T+1, `cpu_ready` again at T+2.
- Clean miss:
  - T+1 COMPARE (miss);
  - T+2 onward `mem_req_valid` until `mem_ready` at cycle M;
  - M+1 COMPARE, `cpu_resp_valid`.
- Dirty miss: a writeback phase precedes the refill. `mem_req_valid` stays high across the WRITEBACK→ALLOCATE transition, with the address and `mem_req_write` changing.
- `mem_req_*` outputs are stable while `mem_req_valid`=1 within a state. A `mem_ready` arriving outside WRITEBACK/ALLOCATE is ignored.
- Reset mid-miss: the next edge returns to IDLE and drops `mem_req_valid`. The outstanding memory transfer is abandoned and no tag/data write occurs.
- `cpu_req_*` need only be valid in the accept cycle.

## Structure
- `memory_sub_system_param` package: ADDR_WIDTH, OFFSET_LENGTH, INDEX_LENGTH, TAG_LENGTH, NUM_CACHE_LINES, and typedef enum `cache_state_t`.
- One sub-module: existing `tag_mem`, instantiated internally. Its reset input is tied to the controller's reset with polarity adapted.
- Valid/dirty arrays, FSM, and counters live in `dm_cache_controller`.

## Test plan
- Reset, then load 0x0000_1040 (idx 0x04, tag 0x00001) -> miss; refill req addr 0x0000_1040; resp at M+1; miss_count=1, hit_count=0.
- Load 0x0000_1048 right after -> hit; resp at T+1, no mem_req; hit_count=1.
- Store 0x0000_1044 -> hit, `data_write`=1 with sel 0, dirty[4]=1. Then load 0x0000_2040 -> WRITEBACK addr 0x0000_1040 with write=1, then ALLOCATE addr 0x0000_2040; miss_count=2.
- Delay `mem_ready` 10 cycles in ALLOCATE -> `mem_req_valid` and addr held steady; `cpu_ready`=0 throughout.
- Assert `reset` during ALLOCATE -> next cycle IDLE, `mem_req_valid`=0; the same load then misses again.
- Force counters near max (CNT_WIDTH=4, 16 hits) -> `hit_count` holds 15.
